// File: rtl/reset_sequencer.sv
// Central reset controller: waits for a stable clock lock, releases reset domains
// in ascending order, then arbitrates per-domain soft-reset requests at run time.

module reset_sequencer_checker #(
  parameter int N_DOMAINS = 3
) (
  input logic                 clk,
  input logic                 rst,
  input logic [N_DOMAINS-1:0] rst_out,
  input logic [N_DOMAINS-1:0] soft_ack,
  input logic                 ready,
  input logic                 busy
);

  a_ready_busy_exclusive: assert property (@(posedge clk) disable iff (rst) !(ready && busy));
  a_ready_all_released:   assert property (@(posedge clk) disable iff (rst) ready |-> (rst_out == '0));
  a_ack_onehot:           assert property (@(posedge clk) disable iff (rst) $onehot0(soft_ack));
  a_ack_returns_ready:    assert property (@(posedge clk) disable iff (rst) (soft_ack != '0) |-> ready);

endmodule

module reset_sequencer #(
  parameter int N_DOMAINS   = 3,
  parameter int LOCK_STABLE = 16,
  parameter int STAGE_DELAY = 8,
  parameter int SOFT_LEN    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked,
  input  logic [N_DOMAINS-1:0] soft_req,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic [N_DOMAINS-1:0] soft_ack,
  output logic                 ready,
  output logic                 busy
);

  localparam int MAX_LEN = (LOCK_STABLE > STAGE_DELAY)
                         ? ((LOCK_STABLE > SOFT_LEN) ? LOCK_STABLE : SOFT_LEN)
                         : ((STAGE_DELAY > SOFT_LEN) ? STAGE_DELAY : SOFT_LEN);
  localparam int CNT_W = $clog2(MAX_LEN) + 1;
  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_DOM   = IDX_W'(N_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } state_t;

  logic                 sync1_r;
  logic                 sync2_r;
  logic                 lk_s;
  state_t               state_r;
  state_t               state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_s;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     idx_s;
  logic [N_DOMAINS-1:0] rst_out_r;
  logic [N_DOMAINS-1:0] rst_out_s;
  logic [N_DOMAINS-1:0] soft_ack_r;
  logic [N_DOMAINS-1:0] soft_ack_s;
  logic                 ready_r;
  logic                 ready_s;
  logic                 busy_r;
  logic                 busy_s;

  // Lowest set index wins arbitration.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_DOMAINS-1:0] req);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int j = N_DOMAINS - 1; j >= 0; j--) begin
      if (req[j]) begin
        idx = IDX_W'(j);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [N_DOMAINS-1:0] onehot(input logic [IDX_W-1:0] k);
    logic [N_DOMAINS-1:0] m;
    for (int j = 0; j < N_DOMAINS; j++) begin
      m[j] = (j == int'(k));
    end
    return m;
  endfunction

  // Domains 0..k released, everything above k still held.
  function automatic logic [N_DOMAINS-1:0] above_mask(input logic [IDX_W-1:0] k);
    logic [N_DOMAINS-1:0] m;
    for (int j = 0; j < N_DOMAINS; j++) begin
      m[j] = (j > int'(k));
    end
    return m;
  endfunction

  assign lk_s = sync2_r;

  // Two-flop synchroniser for the asynchronous lock indicator.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= locked;
      sync2_r <= sync1_r;
    end
  end

  // Next-state and next-output logic; lock loss overrides every transition.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    rst_out_s  = rst_out_r;
    soft_ack_s = '0;
    ready_s    = 1'b0;
    busy_s     = 1'b0;
    if (!lk_s && (state_r != ST_HOLD)) begin
      state_s   = ST_HOLD;
      cnt_s     = '0;
      idx_s     = '0;
      rst_out_s = '1;
    end else begin
      case (state_r)
        ST_HOLD: begin
          rst_out_s = '1;
          idx_s     = '0;
          if (!lk_s) begin
            cnt_s = '0;
          end else if (cnt_r == LOCK_LAST) begin
            // Preload so the first RELEASE cycle frees domain 0 immediately.
            state_s = ST_RELEASE;
            cnt_s   = STAGE_LAST;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_r == STAGE_LAST) begin
            rst_out_s = above_mask(idx_r);
            cnt_s     = '0;
            if (idx_r == LAST_DOM) begin
              state_s = ST_RUN;
              idx_s   = '0;
              ready_s = 1'b1;
            end else begin
              idx_s = idx_r + 1'b1;
            end
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end
        ST_RUN: begin
          rst_out_s = '0;
          if (|soft_req) begin
            state_s   = ST_SOFT;
            idx_s     = lowest_set(soft_req);
            rst_out_s = onehot(lowest_set(soft_req));
            cnt_s     = '0;
            busy_s    = 1'b1;
          end else begin
            ready_s = 1'b1;
          end
        end
        ST_SOFT: begin
          if (cnt_r == SOFT_LAST) begin
            rst_out_s  = '0;
            soft_ack_s = onehot(idx_r);
            state_s    = ST_RUN;
            cnt_s      = '0;
            ready_s    = 1'b1;
          end else begin
            cnt_s  = cnt_r + 1'b1;
            busy_s = 1'b1;
          end
        end
        default: begin
          state_s   = ST_HOLD;
          cnt_s     = '0;
          idx_s     = '0;
          rst_out_s = '1;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_HOLD;
      cnt_r      <= '0;
      idx_r      <= '0;
      rst_out_r  <= '1;
      soft_ack_r <= '0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      rst_out_r  <= rst_out_s;
      soft_ack_r <= soft_ack_s;
      ready_r    <= ready_s;
      busy_r     <= busy_s;
    end
  end

  assign rst_out  = rst_out_r;
  assign soft_ack = soft_ack_r;
  assign ready    = ready_r;
  assign busy     = busy_r;

  reset_sequencer_checker #(
    .N_DOMAINS (N_DOMAINS)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .rst_out  (rst_out_r),
    .soft_ack (soft_ack_r),
    .ready    (ready_r),
    .busy     (busy_r)
  );

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed plus randomized bench for reset_sequencer, checked every cycle against
// a timeline model built from release times and soft-reset windows.

module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int LS = 16;
  localparam int SD = 8;
  localparam int SL = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         locked;
  logic [N-1:0] soft_req;
  logic [N-1:0] rst_out;
  logic [N-1:0] soft_ack;
  logic         ready;
  logic         busy;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model: sync pipeline, lock run length, time of first release,
  // and the domain/start time of the soft reset being served.
  int m_s1, m_s2, m_run, m_seq, m_dom, m_start;
  logic [N-1:0] e_rst, e_ack;
  logic         e_ready, e_busy;

  reset_sequencer #(
    .N_DOMAINS   (N),
    .LOCK_STABLE (LS),
    .STAGE_DELAY (SD),
    .SOFT_LEN    (SL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .locked   (locked),
    .soft_req (soft_req),
    .rst_out  (rst_out),
    .soft_ack (soft_ack),
    .ready    (ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int  lk;
    int  ack_dom;
    bit  run_pre;
    cyc++;
    ack_dom = -1;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_run = 0; m_seq = -1; m_dom = -1;
    end else begin
      lk   = m_s2;
      m_s2 = m_s1;
      m_s1 = locked ? 1 : 0;
      run_pre = (m_seq >= 0) && ((cyc - 1) - m_seq >= (N - 1) * SD);
      if (m_seq < 0) begin
        if (lk != 0) begin
          m_run++;
          if (m_run == LS) begin
            m_seq = cyc + 1;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (lk == 0) begin
        m_seq = -1; m_run = 0; m_dom = -1;
      end else if (m_dom >= 0) begin
        if (cyc - m_start == SL) begin
          ack_dom = m_dom;
          m_dom   = -1;
        end
      end else if (run_pre && (soft_req != '0)) begin
        for (int j = N - 1; j >= 0; j--) if (soft_req[j]) m_dom = j;
        m_start = cyc;
      end
    end
    e_ack = '0;
    if (ack_dom >= 0) e_ack[ack_dom] = 1'b1;
    e_ready = 1'b0;
    e_busy  = 1'b0;
    if (m_seq < 0 || cyc < m_seq) begin
      e_rst = '1;
    end else begin
      e_rst = '0;
      for (int j = 0; j < N; j++) if (j * SD > cyc - m_seq) e_rst[j] = 1'b1;
      if (e_rst == '0) begin
        if (m_dom >= 0) begin
          e_rst[m_dom] = 1'b1;
          e_busy = 1'b1;
        end else begin
          e_ready = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("rst_out", rst_out, e_rst);
    check_eq("soft_ack", soft_ack, e_ack);
    check_eq("ready", ready, e_ready);
    check_eq("busy", busy, e_busy);
  endtask

  task automatic wait_rst(input logic [N-1:0] v, input int max, input string tag);
    int n = 0;
    while (rst_out !== v && n < max) begin step(); n++; end
    check_eq(tag, rst_out, v);
  endtask

  task automatic wait_ready(input int max, input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < max) begin step(); n++; end
    check_eq(tag, ready, 1'b1);
  endtask

  initial begin
    int n, hi1, hi2, bz, acks, ack1_at, start2_at, ovl, lo_left;
    rst = 1'b1; locked = 1'b1; soft_req = '0;

    // Power-up: reset for 5 cycles, then measure each release interval.
    repeat (5) step();
    check_eq("reset_rst_out", rst_out, 3'b111);
    rst = 1'b0;
    n = 0; while (rst_out[0] && n < 40) begin step(); n++; end
    check_eq("release0_latency", n, 19);
    n = 0; while (rst_out[1] && n < 20) begin step(); n++; end
    check_eq("release1_gap", n, 8);
    n = 0; while (rst_out[2] && n < 20) begin step(); n++; end
    check_eq("release2_gap", n, 8);
    check_eq("ready_with_last", ready, 1'b1);

    // Lock glitch in HOLD at stability count 10.
    rst = 1'b1; step(); rst = 1'b0;
    n = 0; while (m_run != 10 && n < 40) begin step(); n++; end
    locked = 1'b0;
    repeat (3) step();
    locked = 1'b1;
    n = 0; while (rst_out[0] && n < 60) begin step(); n++; end
    check_eq("glitch_release_latency", n, 19);
    wait_ready(40, "glitch_ready");

    // Single soft reset on domain 1.
    soft_req = 3'b010; hi1 = 0; bz = 0; acks = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (rst_out[1]) hi1++;
      if (rst_out[0] || rst_out[2]) check_eq("single_others_low", rst_out & 3'b101, 3'b000);
      if (busy) bz++;
      if (soft_ack[1]) begin acks++; soft_req = '0; end
    end
    check_eq("single_window", hi1, SL);
    check_eq("single_busy", bz, SL);
    check_eq("single_acks", acks, 1);
    check_eq("single_ready_back", ready, 1'b1);

    // Simultaneous requests on domains 1 and 2.
    soft_req = 3'b110; hi1 = 0; hi2 = 0; ovl = 0; ack1_at = -1; start2_at = -1;
    for (int c = 0; c < 16; c++) begin
      step();
      if (rst_out[1]) hi1++;
      if (rst_out[2]) hi2++;
      if (rst_out[2] && start2_at < 0) start2_at = c;
      if (rst_out[1] && rst_out[2]) ovl++;
      if (soft_ack[1]) begin ack1_at = c; soft_req[1] = 1'b0; end
      if (soft_ack[2]) soft_req[2] = 1'b0;
    end
    check_eq("dual_window1", hi1, SL);
    check_eq("dual_window2", hi2, SL);
    check_eq("dual_no_overlap", ovl, 0);
    check_eq("dual_second_start", start2_at, ack1_at + 1);

    // Lock loss during the soft reset of domain 2; request held until served.
    soft_req = 3'b100;
    n = 0; while (!busy && n < 10) begin step(); n++; end
    step();
    locked = 1'b0; acks = 0;
    n = 0; while (rst_out !== 3'b111 && n < 10) begin step(); n++; if (soft_ack != '0) acks++; end
    check_eq("lockloss_soft_within3", (n <= 3), 1'b1);
    repeat (4) begin step(); if (soft_ack != '0) acks++; end
    check_eq("lockloss_soft_no_ack", acks, 0);
    locked = 1'b1;
    n = 0; while (!soft_ack[2] && n < 100) begin step(); n++; end
    check_eq("lockloss_soft_reserved", soft_ack[2], 1'b1);
    soft_req = '0;
    wait_ready(10, "lockloss_soft_ready");

    // Lock loss during RELEASE stage 1.
    locked = 1'b0; repeat (4) step(); locked = 1'b1;
    wait_rst(3'b110, 60, "stage1_reached");
    repeat (2) step();
    locked = 1'b0;
    n = 0; while (rst_out !== 3'b111 && n < 10) begin step(); n++; end
    check_eq("lockloss_release_within3", (n <= 3), 1'b1);
    repeat (3) step();
    locked = 1'b1;
    wait_ready(60, "lockloss_release_ready");

    // Synchronous reset pulse in the middle of RELEASE.
    rst = 1'b1; step(); rst = 1'b0;
    wait_rst(3'b110, 60, "srst_stage1_reached");
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("srst_rst_out", rst_out, 3'b111);
    check_eq("srst_ready", ready, 1'b0);
    wait_ready(60, "srst_ready_again");

    // Random traffic: requests, occasional lock drops and resets.
    lo_left = 0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (lo_left > 0) lo_left--;
      else if ($urandom_range(0, 149) == 0) lo_left = $urandom_range(1, 6);
      locked = (lo_left == 0);
      for (int j = 0; j < N; j++) begin
        if (soft_req[j] && soft_ack[j] && $urandom_range(0, 7) != 0) soft_req[j] = 1'b0;
        else if (!soft_req[j] && $urandom_range(0, 19) == 0) soft_req[j] = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
